// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - pixel strobe in, sync/blanking/coordinate outputs of the VGA timing block
interface vga_sync_generator_if;
    logic       pixel_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pixel_tick,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output line_start,
        output frame_start
    );

    modport slave (
        output pixel_tick,
        input  hsync,
        input  vsync,
        input  video_on,
        input  pixel_x,
        input  pixel_y,
        input  line_start,
        input  frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - 640x480@60 raster timing driven by a pixel-rate clock enable
module vga_sync_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_sync_generator_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_AT = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_AT  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BACK_AT  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_AT = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_AT  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BACK_AT  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [1:0] ST_VISIBLE = 2'd0;
    localparam logic [1:0] ST_FRONT   = 2'd1;
    localparam logic [1:0] ST_SYNC    = 2'd2;
    localparam logic [1:0] ST_BACK    = 2'd3;

    logic [9:0] h_count, v_count, h_next, v_next;
    logic [1:0] h_state, v_state, h_state_next, v_state_next;
    logic       h_wrap, v_wrap;
    logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    // Phase transitions are judged on the count being entered, so the
    // registered outputs line up with the coordinates on the same edge.
    function automatic logic [1:0] phase_next(
        input logic [1:0] st,
        input logic [9:0] cnt,
        input logic [9:0] front_at,
        input logic [9:0] sync_at,
        input logic [9:0] back_at
    );
        logic [1:0] nxt;
        nxt = st;
        case (st)
            ST_VISIBLE: if (cnt == front_at) nxt = ST_FRONT;
            ST_FRONT:   if (cnt == sync_at)  nxt = ST_SYNC;
            ST_SYNC:    if (cnt == back_at)  nxt = ST_BACK;
            default:    if (cnt == 10'd0)    nxt = ST_VISIBLE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        h_wrap       = (h_count == H_LAST);
        v_wrap       = h_wrap && (v_count == V_LAST);
        h_next       = h_wrap ? 10'd0 : h_count + 10'd1;
        v_next       = v_count;
        v_state_next = v_state;
        if (h_wrap) begin
            v_next       = v_wrap ? 10'd0 : v_count + 10'd1;
            v_state_next = phase_next(v_state, v_next, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
        end
        h_state_next = phase_next(h_state, h_next, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count       <= 10'd0;
            v_count       <= 10'd0;
            h_state       <= ST_VISIBLE;
            v_state       <= ST_VISIBLE;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= vga.pixel_tick && h_wrap;
            frame_start_q <= vga.pixel_tick && v_wrap;
            if (vga.pixel_tick) begin
                h_count    <= h_next;
                v_count    <= v_next;
                h_state    <= h_state_next;
                v_state    <= v_state_next;
                hsync_q    <= (h_state_next == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync_q    <= (v_state_next == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                video_on_q <= (h_state_next == ST_VISIBLE) && (v_state_next == ST_VISIBLE);
            end
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = h_count;
    assign vga.pixel_y     = v_count;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - scoreboard bench for full-size and miniature sync generator instances
module tb_vga_sync_generator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;

    always #5 clock = ~clock;

    vga_sync_generator_if if_a();
    vga_sync_generator_if if_b();
    assign if_a.pixel_tick = tick;
    assign if_b.pixel_tick = tick;

    vga_sync_generator dut_a (
        .clock (clock),
        .reset (reset),
        .vga   (if_a)
    );

    // Miniature raster (15 x 10, active-high sync) so whole frames fit in a short run.
    vga_sync_generator #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .SYNC_POL  (1'b1)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .vga   (if_b)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    int total = 0;
    int bad   = 0;

    obs_t q_a[$];
    obs_t q_b[$];

    int p_hv [2] = '{640, 8};
    int p_hf [2] = '{16, 2};
    int p_hs [2] = '{96, 3};
    int p_hb [2] = '{48, 2};
    int p_vv [2] = '{480, 6};
    int p_vf [2] = '{10, 1};
    int p_vs [2] = '{2, 2};
    int p_vb [2] = '{33, 1};
    bit p_pol [2] = '{1'b0, 1'b1};

    int   mx [2];
    int   my [2];
    obs_t last [2];

    bit win = 1'b0;
    int n_ls, n_fs, n_von, n_vs, n_ovl;

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s @%0t: got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                         nm, $time, act.hs, act.vs, act.von, act.x, act.y, act.ls, act.fs,
                         exp.hs, exp.vs, exp.von, exp.x, exp.y, exp.ls, exp.fs);
        end
    endtask

    // Reference raster: position after the edge, with sync/blank decoded from that position.
    task automatic model_step(input int k, input bit rst, input bit tk, output obs_t o);
        int ht, vt;
        bit hw, vw, pol;
        ht  = p_hv[k] + p_hf[k] + p_hs[k] + p_hb[k];
        vt  = p_vv[k] + p_vf[k] + p_vs[k] + p_vb[k];
        pol = p_pol[k];
        o   = last[k];
        o.ls = 1'b0;
        o.fs = 1'b0;
        if (rst) begin
            mx[k] = 0;
            my[k] = 0;
            o.hs  = !pol;
            o.vs  = !pol;
            o.von = 1'b0;
            o.x   = 10'd0;
            o.y   = 10'd0;
        end else if (tk) begin
            hw = (mx[k] == ht - 1);
            vw = hw && (my[k] == vt - 1);
            mx[k] = hw ? 0 : mx[k] + 1;
            if (hw) my[k] = vw ? 0 : my[k] + 1;
            o.x   = 10'(mx[k]);
            o.y   = 10'(my[k]);
            o.hs  = (mx[k] >= p_hv[k] + p_hf[k] && mx[k] < p_hv[k] + p_hf[k] + p_hs[k]) ? pol : !pol;
            o.vs  = (my[k] >= p_vv[k] + p_vf[k] && my[k] < p_vv[k] + p_vf[k] + p_vs[k]) ? pol : !pol;
            o.von = (mx[k] < p_hv[k]) && (my[k] < p_vv[k]);
            o.ls  = hw;
            o.fs  = vw;
        end
        last[k] = o;
    endtask

    obs_t act_a, act_b, exp_a, exp_b;

    always @(posedge clock) begin
        #1;
        if (q_a.size() > 0) begin
            exp_a = q_a.pop_front();
            act_a = {if_a.hsync, if_a.vsync, if_a.video_on, if_a.pixel_x, if_a.pixel_y,
                     if_a.line_start, if_a.frame_start};
            check_obs("scoreboard_a", act_a, exp_a);
        end
        if (q_b.size() > 0) begin
            exp_b = q_b.pop_front();
            act_b = {if_b.hsync, if_b.vsync, if_b.video_on, if_b.pixel_x, if_b.pixel_y,
                     if_b.line_start, if_b.frame_start};
            check_obs("scoreboard_b", act_b, exp_b);
        end
    end

    task automatic cyc(input bit rst, input bit tk);
        obs_t ea, eb;
        @(negedge clock);
        reset = rst;
        tick  = tk;
        model_step(0, rst, tk, ea);
        model_step(1, rst, tk, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clock);
        #1;
        if (win) begin
            if (if_b.line_start)  n_ls++;
            if (if_b.frame_start) n_fs++;
            if (tk) begin
                if (if_b.video_on) n_von++;
                if (if_b.vsync)    n_vs++;
                if (if_b.video_on && (if_b.hsync || if_b.vsync)) n_ovl++;
            end
        end
    endtask

    int stall_pulses;

    initial begin
        repeat (3) cyc(1'b1, 1'b0);
        check_int("reset_x_a", int'(if_a.pixel_x), 0);
        check_int("reset_y_a", int'(if_a.pixel_y), 0);
        check_int("reset_hsync_a", int'(if_a.hsync), 1);
        check_int("reset_vsync_a", int'(if_a.vsync), 1);
        check_int("reset_video_on_a", int'(if_a.video_on), 0);
        check_int("reset_hsync_b", int'(if_b.hsync), 0);

        // Line timing with ticks on alternate clocks.
        for (int t = 1; t <= 800; t++) begin
            cyc(1'b0, 1'b1);
            if (t == 639) check_int("von_tick639", int'(if_a.video_on), 1);
            if (t == 640) check_int("von_tick640", int'(if_a.video_on), 0);
            if (t == 655) check_int("hsync_tick655", int'(if_a.hsync), 1);
            if (t == 656) check_int("hsync_tick656", int'(if_a.hsync), 0);
            if (t == 751) check_int("hsync_tick751", int'(if_a.hsync), 0);
            if (t == 752) check_int("hsync_tick752", int'(if_a.hsync), 1);
            if (t == 800) begin
                check_int("line_start_tick800", int'(if_a.line_start), 1);
                check_int("x_after_line", int'(if_a.pixel_x), 0);
                check_int("y_after_line", int'(if_a.pixel_y), 1);
            end
            cyc(1'b0, 1'b0);
            if (t == 800) check_int("line_start_one_clock", int'(if_a.line_start), 0);
        end

        // Advance to (123,45), stall, then resume.
        for (int i = 0; i < 44 * 800 + 123; i++) cyc(1'b0, 1'b1);
        check_int("stall_x_before", int'(if_a.pixel_x), 123);
        check_int("stall_y_before", int'(if_a.pixel_y), 45);
        stall_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0);
            if (if_a.line_start || if_a.frame_start) stall_pulses++;
        end
        check_int("stall_pulses", stall_pulses, 0);
        check_int("stall_x_frozen", int'(if_a.pixel_x), 123);
        cyc(1'b0, 1'b1);
        check_int("resume_x", int'(if_a.pixel_x), 124);
        check_int("resume_y", int'(if_a.pixel_y), 45);

        // One miniature frame, continuous ticks (m=0) then alternate ticks (m=1).
        for (int m = 0; m < 2; m++) begin
            cyc(1'b1, 1'b0);
            n_ls = 0; n_fs = 0; n_von = 0; n_vs = 0; n_ovl = 0;
            win = 1'b1;
            for (int i = 0; i < 150; i++) begin
                cyc(1'b0, 1'b1);
                if (m == 1) cyc(1'b0, 1'b0);
            end
            win = 1'b0;
            check_int("frame_line_starts", n_ls, 10);
            check_int("frame_frame_starts", n_fs, 1);
            check_int("frame_visible_ticks", n_von, 48);
            check_int("frame_vsync_ticks", n_vs, 30);
            check_int("frame_visible_in_sync", n_ovl, 0);
            check_int("frame_wrap_video_on", int'(if_b.video_on), 1);
        end

        // Reset mid-frame on both instances; on dut_b it collides with a frame wrap.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 149; i++) cyc(1'b0, 1'b1);
        check_int("pre_reset_x_b", int'(if_b.pixel_x), 14);
        check_int("pre_reset_y_b", int'(if_b.pixel_y), 9);
        cyc(1'b1, 1'b1);
        check_int("midreset_x_b", int'(if_b.pixel_x), 0);
        check_int("midreset_y_b", int'(if_b.pixel_y), 0);
        check_int("midreset_frame_start_b", int'(if_b.frame_start), 0);
        check_int("midreset_line_start_b", int'(if_b.line_start), 0);
        check_int("midreset_video_on_b", int'(if_b.video_on), 0);
        check_int("midreset_vsync_b", int'(if_b.vsync), 0);
        check_int("midreset_x_a", int'(if_a.pixel_x), 0);
        check_int("midreset_hsync_a", int'(if_a.hsync), 1);
        cyc(1'b0, 1'b0);
        check_int("reset_exit_pulse", int'(if_b.line_start | if_b.frame_start), 0);
        repeat (20) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
